// File: rtl/rv32i_types.sv
// Shared RV32I rename-stage types.
// Holds the physical/architectural register counts and the physical
// register index type used by the free list, retired RAT, speculative
// RAT and ROB.
package rv32i_types;

    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int PHYS_REG_W    = $clog2(NUM_PHYS_REGS);

    typedef logic [PHYS_REG_W-1:0] phys_idx_t;

endpackage

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical-register indices.
//
// Rename pops the head index (alloc_req) to allocate a destination; the
// retired RAT pushes the evicted physical index (enqueue/enq_ps_idx) at
// commit. On flush the list restores itself to the committed state in one
// cycle by moving head to one full lap behind the (post-free) tail.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   enqueue      in   commit frees a physical register
//   enq_ps_idx   in   freed physical index
//   alloc_req    in   rename consumes the head index this cycle
//   alloc_ps_idx out  index at head, valid while !empty
//   flush        in   mispredict/exception recovery
//   full         out  all DEPTH entries free
//   empty        out  no free entries, rename must stall
//   count        out  number of free entries
module free_list
    import rv32i_types::*;
#(
    parameter int NUM_PHYS_REGS_P = NUM_PHYS_REGS,
    parameter int NUM_ARCH_REGS_P = NUM_ARCH_REGS,
    parameter int DEPTH           = NUM_PHYS_REGS_P - NUM_ARCH_REGS_P,
    parameter int PR_W            = $clog2(NUM_PHYS_REGS_P)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enqueue,
    input  logic [PR_W-1:0]            enq_ps_idx,
    input  logic                       alloc_req,
    output logic [PR_W-1:0]            alloc_ps_idx,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W-1:0] tail_next;

    logic [PR_W-1:0]  entry_reg [DEPTH];

    logic             do_alloc;
    logic             do_free;

    always_comb begin
        count        = tail_reg - head_reg;
        full         = (count == PTR_W'(DEPTH));
        empty        = (count == '0);
        alloc_ps_idx = entry_reg[head_reg[IDX_W-1:0]];
    end

    always_comb begin
        do_alloc  = alloc_req && !empty && !flush;
        do_free   = enqueue && !full;

        tail_next = tail_reg;
        if (do_free) begin
            tail_next = tail_reg + PTR_W'(1);
        end

        head_next = head_reg;
        if (flush) begin
            // One lap behind tail: every slot in the ring becomes free again.
            // Slots past the committed frees still hold the indices handed to
            // squashed instructions, so they are reclaimed as-is.
            head_next = {~tail_next[PTR_W-1], tail_next[IDX_W-1:0]};
        end else if (do_alloc) begin
            head_next = head_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg <= '0;
            tail_reg <= PTR_W'(DEPTH);
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    // Each slot resets to its own initial free index (NUM_ARCH_REGS + slot),
    // so the storage is per-slot registers rather than a RAM.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_reg[gi] <= PR_W'(NUM_ARCH_REGS_P + gi);
                end else if (do_free && (tail_reg[IDX_W-1:0] == IDX_W'(gi))) begin
                    entry_reg[gi] <= enq_ps_idx;
                end
            end
        end
    endgenerate

    // Physical register 0 is never freed; the entry is still written.
    a_no_free_zero: assert property (
        @(posedge clk) disable iff (!rst) !(enqueue && (enq_ps_idx == '0))
    );

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

    localparam int DEPTH = 32;
    localparam int PR_W  = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enqueue = 1'b0;
    logic [PR_W-1:0] enq_ps_idx = '0;
    logic            alloc_req = 1'b0;
    logic [PR_W-1:0] alloc_ps_idx;
    logic            flush = 1'b0;
    logic            full;
    logic            empty;
    logic [5:0]      count;

    int checks = 0;
    int errors = 0;

    // Reference model: an unbounded log of every index ever placed in the
    // list, in order. Free entries are log[mhead .. log.size()-1]. A flush
    // makes the last DEPTH logged indices free again.
    int mlog[$];
    int mhead;

    free_list dut (
        .clk          (clk),
        .rst          (rst),
        .enqueue      (enqueue),
        .enq_ps_idx   (enq_ps_idx),
        .alloc_req    (alloc_req),
        .alloc_ps_idx (alloc_ps_idx),
        .flush        (flush),
        .full         (full),
        .empty        (empty),
        .count        (count)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        return mlog.size() - mhead;
    endfunction

    function automatic int m_head_idx();
        return (m_count() > 0) ? mlog[mhead] : -1;
    endfunction

    task automatic model_reset();
        mlog.delete();
        for (int i = 0; i < DEPTH; i++) mlog.push_back(32 + i);
        mhead = 0;
    endtask

    // Drives one cycle of inputs, lets the edge happen, advances the model.
    task automatic drive_cycle(input logic a, input logic e, input int idx, input logic f);
        int c;
        alloc_req  = a;
        enqueue    = e;
        enq_ps_idx = PR_W'(idx);
        flush      = f;
        c = m_count();
        @(posedge clk);
        if (e && c < DEPTH) mlog.push_back(idx);
        if (f) mhead = mlog.size() - DEPTH;
        else if (a && c > 0) mhead++;
        #1;
        alloc_req  = 1'b0;
        enqueue    = 1'b0;
        enq_ps_idx = '0;
        flush      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count !== 6'd32) begin errors++; $display("FAIL reset_count: got %0d expected 32", count); end
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL reset_full: got %0b expected 1", full); end
        checks++;
        if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %0b expected 0", empty); end
        checks++;
        if (alloc_ps_idx !== 6'd32) begin errors++; $display("FAIL reset_alloc_idx: got %0d expected 32", alloc_ps_idx); end
        $display("reset: count=%0d full=%0b empty=%0b idx=%0d", count, full, empty, alloc_ps_idx);
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (alloc_ps_idx !== PR_W'(32 + i) || count !== 6'(32 - i)) begin
                errors++;
                $display("FAIL drain_%0d: got idx=%0d count=%0d expected idx=%0d count=%0d",
                         i, alloc_ps_idx, count, 32 + i, 32 - i);
            end
            drive_cycle(1'b1, 1'b0, 0, 1'b0);
        end
        checks++;
        if (empty !== 1'b1 || count !== 6'd0) begin
            errors++; $display("FAIL drain_empty: got empty=%0b count=%0d expected 1/0", empty, count);
        end
        // 33rd allocate must be ignored.
        drive_cycle(1'b1, 1'b0, 0, 1'b0);
        checks++;
        if (count !== 6'd0) begin errors++; $display("FAIL alloc_when_empty: got count=%0d expected 0", count); end
        drive_cycle(1'b0, 1'b1, 5, 1'b0);
        checks++;
        if (count !== 6'd1 || alloc_ps_idx !== 6'd5) begin
            errors++; $display("FAIL free_5: got count=%0d idx=%0d expected 1/5", count, alloc_ps_idx);
        end
        drive_cycle(1'b1, 1'b0, 0, 1'b0);
        // Empty: same-cycle free + alloc, alloc ignored.
        drive_cycle(1'b1, 1'b1, 6, 1'b0);
        checks++;
        if (count !== 6'd1 || alloc_ps_idx !== 6'd6) begin
            errors++; $display("FAIL empty_alloc_free: got count=%0d idx=%0d expected 1/6", count, alloc_ps_idx);
        end
        $display("drain: count=%0d idx=%0d", count, alloc_ps_idx);
    endtask

    task automatic test_flush();
        int got;
        bit seen[64];
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 0, 1'b0);
        drive_cycle(1'b0, 1'b1, 7, 1'b0);
        drive_cycle(1'b0, 1'b1, 9, 1'b0);
        drive_cycle(1'b1, 1'b0, 0, 1'b1);
        checks++;
        if (count !== 6'd32 || full !== 1'b1) begin
            errors++; $display("FAIL flush_count: got count=%0d full=%0b expected 32/1", count, full);
        end
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            got = int'(alloc_ps_idx);
            checks++;
            if (got !== m_head_idx() || seen[got]) begin
                errors++; $display("FAIL flush_drain_%0d: got %0d expected %0d (dup=%0b)", i, got, m_head_idx(), seen[got]);
            end
            seen[got] = 1'b1;
            drive_cycle(1'b1, 1'b0, 0, 1'b0);
        end
        checks++;
        if (!(seen[7] && seen[9] && seen[34] && !seen[32] && !seen[33])) begin
            errors++; $display("FAIL flush_set: got 7:%0b 9:%0b 34:%0b 32:%0b 33:%0b expected 1 1 1 0 0",
                               seen[7], seen[9], seen[34], seen[32], seen[33]);
        end
        $display("flush: drained 32 after recovery, count=%0d", count);
    endtask

    task automatic test_flush_enqueue();
        int last;
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 0, 1'b0);
        drive_cycle(1'b1, 1'b1, 12, 1'b1);
        checks++;
        if (count !== 6'd32) begin errors++; $display("FAIL flush_enq_count: got %0d expected 32", count); end
        last = -1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (int'(alloc_ps_idx) !== m_head_idx()) begin
                errors++; $display("FAIL flush_enq_drain_%0d: got %0d expected %0d", i, alloc_ps_idx, m_head_idx());
            end
            last = int'(alloc_ps_idx);
            drive_cycle(1'b1, 1'b0, 0, 1'b0);
        end
        checks++;
        if (last !== 12) begin errors++; $display("FAIL flush_enq_last: got %0d expected 12", last); end
        $display("flush_enqueue: last allocated=%0d", last);
    endtask

    task automatic test_wrap();
        int pool[$];
        bit in_use[64];
        int allocs = 0;
        int frees = 0;
        do_reset();
        for (int i = 0; i < 64; i++) in_use[i] = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            logic a, e;
            int idx, k;
            a = ($urandom_range(9, 0) < 6);
            e = (pool.size() > 0) && ($urandom_range(1, 0) == 1);
            idx = 0;
            if (e) begin
                k = $urandom_range(pool.size() - 1, 0);
                idx = pool[k];
                pool.delete(k);
                in_use[idx] = 1'b0;
                frees++;
            end
            checks++;
            if (int'(count) !== m_count() || full !== (m_count() == DEPTH) || empty !== (m_count() == 0)) begin
                errors++; $display("FAIL wrap_flags_%0d: got count=%0d full=%0b empty=%0b expected count=%0d",
                                   cyc, count, full, empty, m_count());
            end
            if (a && m_count() > 0) begin
                checks++;
                if (int'(alloc_ps_idx) !== m_head_idx() || in_use[alloc_ps_idx]) begin
                    errors++; $display("FAIL wrap_alloc_%0d: got %0d expected %0d (dup=%0b)",
                                       cyc, alloc_ps_idx, m_head_idx(), in_use[alloc_ps_idx]);
                end
                in_use[alloc_ps_idx] = 1'b1;
                pool.push_back(int'(alloc_ps_idx));
                allocs++;
            end
            drive_cycle(a, e, idx, 1'b0);
        end
        checks++;
        if (int'(count) !== DEPTH - pool.size()) begin
            errors++; $display("FAIL wrap_conservation: got count=%0d expected %0d", count, DEPTH - pool.size());
        end
        $display("wrap: allocs=%0d frees=%0d count=%0d", allocs, frees, count);
    endtask

    task automatic test_random_flush();
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            logic a, e, f;
            a = $urandom_range(1, 0) == 1;
            e = $urandom_range(2, 0) == 0;
            f = $urandom_range(15, 0) == 0;
            checks++;
            if (int'(count) !== m_count() || full !== (m_count() == DEPTH) || empty !== (m_count() == 0) ||
                (m_count() > 0 && int'(alloc_ps_idx) !== m_head_idx())) begin
                errors++; $display("FAIL rand_%0d: got count=%0d idx=%0d full=%0b empty=%0b expected count=%0d idx=%0d",
                                   cyc, count, alloc_ps_idx, full, empty, m_count(), m_head_idx());
            end
            drive_cycle(a, e, $urandom_range(63, 1), f);
        end
        $display("random_flush: count=%0d", count);
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 15; i++) drive_cycle(1'b1, 1'b0, 0, 1'b0);
        checks++;
        if (count !== 6'd17) begin errors++; $display("FAIL pre_reset_count: got %0d expected 17", count); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (count !== 6'd32 || full !== 1'b1 || alloc_ps_idx !== 6'd32) begin
            errors++; $display("FAIL async_reset: got count=%0d full=%0b idx=%0d expected 32/1/32",
                               count, full, alloc_ps_idx);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        $display("async_reset: count=%0d full=%0b idx=%0d", count, full, alloc_ps_idx);
    endtask

    initial begin
        test_reset();
        test_drain();
        test_flush();
        test_flush_enqueue();
        test_wrap();
        test_random_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
